// File: rtl/decoder_2x4_scan_seq.sv
// -----------------------------------------------------------------------------
// decoder_2x4_scan_seq
//
// Upstream sequencer for a 2x4 decoder. Produces the select (a) and enable
// (en) the decoder consumes. It scans the enabled lines in ascending order,
// holds each line for a programmable dwell time, and forces en low for
// BLANK_CYC cycles around every select change (break-before-make), so two
// decoder outputs are never active together.
//
// Parameters
//   DWELL_W    width of the dwell input
//   BLANK_CYC  cycles of en=0 after each select change (0 = no gap)
//
// Ports
//   clk         in   1        system clock, rising edge
//   rst_n       in   1        synchronous reset, active-low
//   start       in   1        request to begin scanning (honoured in IDLE only)
//   stop        in   1        request to end scanning (sticky until IDLE)
//   line_mask   in   4        bit i=1 includes line i in the scan
//   dwell       in   DWELL_W  cycles en stays high per line (0 acts as 1)
//   a           out  2        decoder select, registered
//   en          out  1        decoder enable, registered
//   busy        out  1        high whenever the sequencer is not IDLE
//   frame_done  out  1        1-cycle pulse after the highest enabled line
// -----------------------------------------------------------------------------
module decoder_2x4_scan_seq #(
  parameter int DWELL_W   = 8,
  parameter int BLANK_CYC = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               stop,
  input  logic [3:0]         line_mask,
  input  logic [DWELL_W-1:0] dwell,
  output logic [1:0]         a,
  output logic               en,
  output logic               busy,
  output logic               frame_done
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_BLANK = 2'd1;
  localparam logic [1:0] S_DRIVE = 2'd2;

  // Blank counter counts down from BLANK_CYC-1 to 0; keep it at least 1 bit.
  localparam int              BW         = (BLANK_CYC > 1) ? $clog2(BLANK_CYC) : 1;
  localparam logic [BW-1:0]   BLANK_LOAD = (BLANK_CYC > 0) ? BW'(BLANK_CYC - 1) : '0;

  logic [1:0]         r_state;
  logic [3:0]         r_mask;
  logic [DWELL_W-1:0] r_dwell;
  logic [DWELL_W-1:0] r_dwell_cnt;
  logic [BW-1:0]      r_blank_cnt;
  logic               r_stop_req;
  logic [1:0]         r_a;
  logic               r_en;
  logic               r_frame_done;

  logic [1:0]         w_first;
  logic [1:0]         w_next;
  logic [1:0]         w_last;
  logic [DWELL_W-1:0] w_dwell_load;
  logic [DWELL_W-1:0] w_in_dwell_load;
  logic               w_stop;
  logic               w_go;

  // Lowest set bit of the mask (0 if the mask is empty).
  function automatic logic [1:0] f_lowest(input logic [3:0] m);
    f_lowest = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (m[i]) f_lowest = 2'(i);
    end
  endfunction

  // Highest set bit of the mask.
  function automatic logic [1:0] f_highest(input logic [3:0] m);
    f_highest = 2'd0;
    for (int i = 0; i < 4; i++) begin
      if (m[i]) f_highest = 2'(i);
    end
  endfunction

  // Next enabled index above cur, wrapping 3->0; cur itself if it is the
  // only enabled line. Descending k lets the nearest candidate win.
  function automatic logic [1:0] f_next(input logic [3:0] m, input logic [1:0] cur);
    logic [1:0] idx;
    f_next = cur;
    for (int k = 3; k >= 1; k--) begin
      idx = cur + 2'(k);
      if (m[idx]) f_next = idx;
    end
  endfunction

  assign w_first = f_lowest(line_mask);
  assign w_next  = f_next(r_mask, r_a);
  assign w_last  = f_highest(r_mask);

  // Dwell counter is loaded with max(dwell,1)-1 so a zero dwell still gives
  // one enabled cycle.
  assign w_dwell_load    = (r_dwell == '0) ? '0 : r_dwell - DWELL_W'(1);
  assign w_in_dwell_load = (dwell   == '0) ? '0 : dwell   - DWELL_W'(1);

  // A stop seen in the current cycle acts immediately, same as a latched one.
  assign w_stop = stop | r_stop_req;
  assign w_go   = start && !stop && (line_mask != 4'b0000);

  // NOTE: every register below is assigned with <= so all of them update
  // together from the values present before the edge; a blocking = here
  // would let later statements see half-updated state.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state      <= S_IDLE;
      r_mask       <= '0;
      r_dwell      <= '0;
      r_dwell_cnt  <= '0;
      r_blank_cnt  <= '0;
      r_stop_req   <= 1'b0;
      r_a          <= 2'b00;
      r_en         <= 1'b0;
      r_frame_done <= 1'b0;
    end else begin
      r_frame_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          r_en       <= 1'b0;
          r_stop_req <= 1'b0;
          if (w_go) begin
            r_mask  <= line_mask;
            r_dwell <= dwell;
            r_a     <= w_first;
            if (BLANK_CYC == 0) begin
              r_state     <= S_DRIVE;
              r_en        <= 1'b1;
              r_dwell_cnt <= w_in_dwell_load;
            end else begin
              r_state     <= S_BLANK;
              r_blank_cnt <= BLANK_LOAD;
            end
          end
        end

        S_BLANK: begin
          if (w_stop) begin
            r_state    <= S_IDLE;
            r_stop_req <= 1'b0;
          end else if (r_blank_cnt == '0) begin
            r_state     <= S_DRIVE;
            r_en        <= 1'b1;
            r_dwell_cnt <= w_dwell_load;
          end else begin
            r_blank_cnt <= r_blank_cnt - BW'(1);
          end
        end

        S_DRIVE: begin
          if (stop) r_stop_req <= 1'b1;
          if (r_dwell_cnt == '0) begin
            if (w_stop) begin
              // Stop exit: select is held and no frame_done is reported.
              r_state    <= S_IDLE;
              r_en       <= 1'b0;
              r_stop_req <= 1'b0;
            end else begin
              r_a          <= w_next;
              r_frame_done <= (r_a == w_last);
              if (BLANK_CYC == 0) begin
                r_dwell_cnt <= w_dwell_load;
              end else begin
                r_state     <= S_BLANK;
                r_en        <= 1'b0;
                r_blank_cnt <= BLANK_LOAD;
              end
            end
          end else begin
            r_dwell_cnt <= r_dwell_cnt - DWELL_W'(1);
          end
        end

        default: begin
          r_state <= S_IDLE;
          r_en    <= 1'b0;
        end
      endcase
    end
  end

  assign a          = r_a;
  assign en         = r_en;
  assign busy       = (r_state != S_IDLE);
  assign frame_done = r_frame_done;

endmodule

// File: tb/tb_decoder_2x4_scan_seq.sv
// -----------------------------------------------------------------------------
// tb_decoder_2x4_scan_seq
//
// Self-checking bench for decoder_2x4_scan_seq (DWELL_W=8, BLANK_CYC=2).
// A table of per-cycle vectors covers reset and a full scan pass; short
// hand-written sequences cover the masked scan, empty mask, zero dwell,
// stop handling and mid-scan reset. A monitor checks that a is stable
// whenever en is high.
// -----------------------------------------------------------------------------
module tb_decoder_2x4_scan_seq;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic       stop;
  logic [3:0] line_mask;
  logic [7:0] dwell;
  logic [1:0] a;
  logic       en;
  logic       busy;
  logic       frame_done;

  int n_checks = 0;
  int n_errors = 0;

  decoder_2x4_scan_seq #(.DWELL_W(8), .BLANK_CYC(2)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .stop       (stop),
    .line_mask  (line_mask),
    .dwell      (dwell),
    .a          (a),
    .en         (en),
    .busy       (busy),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;

  typedef struct {
    string      name;
    logic       rst_n;
    logic       start;
    logic       stop;
    logic [3:0] mask;
    logic [7:0] dwell;
    logic [1:0] exp_a;
    logic       exp_en;
    logic       exp_busy;
    logic       exp_fd;
    int         reps;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input string name, input logic r, input logic s, input logic p,
                     input logic [3:0] m, input logic [7:0] d, input logic [1:0] ea,
                     input logic ee, input logic eb, input logic ef, input int reps);
    vec_t v;
    v.name = name; v.rst_n = r; v.start = s; v.stop = p; v.mask = m; v.dwell = d;
    v.exp_a = ea; v.exp_en = ee; v.exp_busy = eb; v.exp_fd = ef; v.reps = reps;
    vecs.push_back(v);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic r, input logic s, input logic p,
                       input logic [3:0] m, input logic [7:0] d);
    rst_n = r; start = s; stop = p; line_mask = m; dwell = d;
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Expected {a,en,busy,frame_done} packed for one comparison.
  function automatic logic [31:0] pk(input logic [1:0] ea, input logic ee,
                                     input logic eb, input logic ef);
    pk = {27'd0, ea, ee, eb, ef};
  endfunction

  task automatic wait_idle(input string name, input int budget);
    int n;
    n = 0;
    while (busy !== 1'b0 && n < budget) begin
      tick();
      n++;
    end
    check({name, "_idle_timeout"}, {31'd0, busy}, 32'd0);
  endtask

  // a must not move while en is high (covers en rising together with a change).
  logic       mon_on = 1'b0;
  logic [1:0] prev_a;
  always @(negedge clk) begin
    if (mon_on && en === 1'b1) begin
      n_checks++;
      if (a !== prev_a) begin
        n_errors++;
        $display("FAIL mon_a_stable: got a=%0d expected a=%0d at %0t", a, prev_a, $time);
      end
    end
    prev_a = a;
  end

  initial begin
    drive(1'b0, 1'b0, 1'b0, 4'hF, 8'd3);

    // Test 1: full pass, mask=F dwell=3. After start the inputs are changed
    // to mask=1, dwell=1 and start is re-asserted: all must be ignored.
    add("reset",   0, 0, 0, 4'hF, 8'd3, 2'd0, 0, 0, 0, 1);
    add("idle",    1, 0, 0, 4'hF, 8'd3, 2'd0, 0, 0, 0, 1);
    add("start",   1, 1, 0, 4'hF, 8'd3, 2'd0, 0, 1, 0, 1);
    add("blank0",  1, 0, 0, 4'h1, 8'd1, 2'd0, 0, 1, 0, 1);
    add("drive0",  1, 0, 0, 4'h1, 8'd1, 2'd0, 1, 1, 0, 3);
    add("blank1",  1, 1, 0, 4'h1, 8'd1, 2'd1, 0, 1, 0, 2);
    add("drive1",  1, 0, 0, 4'h1, 8'd1, 2'd1, 1, 1, 0, 3);
    add("blank2",  1, 0, 0, 4'h1, 8'd1, 2'd2, 0, 1, 0, 2);
    add("drive2",  1, 0, 0, 4'h1, 8'd1, 2'd2, 1, 1, 0, 3);
    add("blank3",  1, 0, 0, 4'h1, 8'd1, 2'd3, 0, 1, 0, 2);
    add("drive3",  1, 0, 0, 4'h1, 8'd1, 2'd3, 1, 1, 0, 3);
    add("frame",   1, 0, 0, 4'h1, 8'd1, 2'd0, 0, 1, 1, 1);
    add("blank0b", 1, 0, 0, 4'h1, 8'd1, 2'd0, 0, 1, 0, 1);
    add("drive0b", 1, 0, 0, 4'h1, 8'd1, 2'd0, 1, 1, 0, 1);

    foreach (vecs[i]) begin
      for (int r = 0; r < vecs[i].reps; r++) begin
        drive(vecs[i].rst_n, vecs[i].start, vecs[i].stop, vecs[i].mask, vecs[i].dwell);
        tick();
        if (vecs[i].rst_n === 1'b0) mon_on = 1'b1;
        check(vecs[i].name, pk(a, en, busy, frame_done),
              pk(vecs[i].exp_a, vecs[i].exp_en, vecs[i].exp_busy, vecs[i].exp_fd));
      end
    end
    drive(1'b1, 1'b0, 1'b1, 4'h1, 8'd1);
    tick();
    drive(1'b1, 1'b0, 1'b0, 4'h1, 8'd1);
    wait_idle("t1_stop", 20);
    check("t1_en_idle", {31'd0, en}, 32'd0);

    // Test 2: mask=1010 dwell=1 -> a alternates 1,3; frame_done after line 3.
    drive(1'b1, 1'b1, 1'b0, 4'b1010, 8'd1);
    for (int j = 0; j < 4; j++) begin
      for (int c = 0; c < 3; c++) begin
        tick();
        drive(1'b1, 1'b0, 1'b0, 4'b1010, 8'd1);
        check("t2_seq", pk(a, en, busy, frame_done),
              pk((j % 2 == 1) ? 2'd3 : 2'd1, c == 2, 1'b1, c == 0 && j > 0 && j % 2 == 0));
      end
    end
    drive(1'b1, 1'b0, 1'b1, 4'b1010, 8'd1);
    tick();
    drive(1'b1, 1'b0, 1'b0, 4'b1010, 8'd1);
    check("t2_stop_exit", pk(a, en, busy, frame_done), pk(2'd3, 0, 0, 0));

    // Test 3a: empty mask -> start ignored.
    drive(1'b1, 1'b1, 1'b0, 4'b0000, 8'd3);
    for (int c = 0; c < 3; c++) begin
      tick();
      drive(1'b1, 1'b0, 1'b0, 4'b0000, 8'd3);
      check("t3_empty_mask", {30'd0, busy, en}, 32'd0);
    end

    // Test 3b: dwell=0, single line 0 -> one en cycle per pass, frame_done each pass.
    drive(1'b1, 1'b1, 1'b0, 4'b0001, 8'd0);
    for (int j = 0; j < 3; j++) begin
      for (int c = 0; c < 3; c++) begin
        tick();
        drive(1'b1, 1'b0, 1'b0, 4'b0001, 8'd0);
        check("t3_dwell0", pk(a, en, busy, frame_done),
              pk(2'd0, c == 2, 1'b1, c == 0 && j > 0));
      end
    end
    drive(1'b1, 1'b0, 1'b1, 4'b0001, 8'd0);
    tick();
    drive(1'b1, 1'b0, 1'b0, 4'b0001, 8'd0);
    check("t3_stop_exit", pk(a, en, busy, frame_done), pk(2'd0, 0, 0, 0));

    // Test 4a: stop in 2nd DRIVE cycle with dwell=4.
    drive(1'b1, 1'b1, 1'b0, 4'hF, 8'd4);
    tick();
    drive(1'b1, 1'b0, 1'b0, 4'hF, 8'd4);
    tick();
    tick();
    check("t4_drive1", pk(a, en, busy, frame_done), pk(2'd0, 1, 1, 0));
    tick();
    check("t4_drive2", pk(a, en, busy, frame_done), pk(2'd0, 1, 1, 0));
    drive(1'b1, 1'b0, 1'b1, 4'hF, 8'd4);
    tick();
    drive(1'b1, 1'b0, 1'b0, 4'hF, 8'd4);
    check("t4_drive3", pk(a, en, busy, frame_done), pk(2'd0, 1, 1, 0));
    tick();
    check("t4_drive4", pk(a, en, busy, frame_done), pk(2'd0, 1, 1, 0));
    tick();
    check("t4_idle", pk(a, en, busy, frame_done), pk(2'd0, 0, 0, 0));
    tick();
    check("t4_idle_hold", pk(a, en, busy, frame_done), pk(2'd0, 0, 0, 0));

    // Test 4b: start and stop together -> stay IDLE.
    drive(1'b1, 1'b1, 1'b1, 4'hF, 8'd4);
    tick();
    drive(1'b1, 1'b0, 1'b0, 4'hF, 8'd4);
    check("t4_start_stop", {30'd0, busy, en}, 32'd0);
    tick();
    check("t4_start_stop_hold", {30'd0, busy, en}, 32'd0);

    // Test 4c: stop in BLANK -> IDLE on the next edge.
    drive(1'b1, 1'b1, 1'b0, 4'hF, 8'd4);
    tick();
    check("t4_blank_busy", {30'd0, busy, en}, 32'd2);
    drive(1'b1, 1'b0, 1'b1, 4'hF, 8'd4);
    tick();
    drive(1'b1, 1'b0, 1'b0, 4'hF, 8'd4);
    check("t4_blank_stop", pk(a, en, busy, frame_done), pk(2'd0, 0, 0, 0));

    // Test 5: reset while en=1 on line 1.
    drive(1'b1, 1'b1, 1'b0, 4'hF, 8'd3);
    tick();
    drive(1'b1, 1'b0, 1'b0, 4'hF, 8'd3);
    for (int c = 0; c < 7; c++) tick();
    check("t5_pre_reset", pk(a, en, busy, frame_done), pk(2'd1, 1, 1, 0));
    drive(1'b0, 1'b0, 1'b0, 4'hF, 8'd3);
    tick();
    check("t5_reset", pk(a, en, busy, frame_done), pk(2'd0, 0, 0, 0));
    drive(1'b1, 1'b0, 1'b0, 4'hF, 8'd3);
    tick();
    check("t5_after_reset", pk(a, en, busy, frame_done), pk(2'd0, 0, 0, 0));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
